ring_phase_monitor: RTL and testbench
=====================================

# ring_phase_monitor

Downstream consumer of the 6-stage Mod-6 ring counter. It samples the one-hot phase vector each cycle and encodes it to a phase index. It checks that the pattern stays one-hot and advances in ring order, and counts full revolutions. It drives lock and sticky fault flags that the control logic uses to gate anything keyed off ring phases.

## Interface
Parameters:
- REV_W, default 8: width of the revolution counter.
- LOCK_CNT, default 3: consecutive correct advances required to declare lock (range 1–15).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  input  1  system clock; all state updates on rising edge.
  - clr  input  1  asynchronous, active-high reset.
- en  input  1  ring counter running; when 0 the monitor freezes.
- phase  input  6  ring outputs; bit0=Qa … bit5=Qf.
- rearm  input  1  single-cycle request to leave FAULT.
- phase_idx  output  3  encoded index 0–5 of the last valid sample.
- valid  output  1  last sample was exactly one-hot.
- locked  output  1  state is LOCKED.
- rev_tick  output  1  one-cycle pulse on index wrap 5→0 while LOCKED.
- rev_count  output  REV_W  revolutions completed, wrapping.
- err_onehot  output  1  sticky: zero or multiple hot bits seen while LOCKED.
- err_seq  output  1  sticky: one-hot but not the ring successor while LOCKED.

## Operation
- The ring counter updates on the falling edge of clk. phase is therefore stable at each rising edge and is sampled directly, with no synchronizer.
- Good advance: the sample is one-hot, a previous valid index exists, and new index = (prev+1) mod 6. A hold (same index) counts as a sequence error.
- States:
  - UNLOCKED (reset state):
    - A good advance increments the lock counter.
    - Reaching LOCK_CNT moves to LOCKED.
    - Any non-one-hot or out-of-order sample clears the lock counter. No error flag is set.
  - LOCKED:
    - A non-one-hot sample moves to FAULT and sets err_onehot.
    - A one-hot sample that is not the successor moves to FAULT and sets err_seq.
    - A good advance from 5 to 0 increments rev_count (wraps at 2^REV_W) and pulses rev_tick.
  - FAULT:
    - Samples are still encoded, but no counting or checking.
    - rearm=1 moves to UNLOCKED, clears both error flags and the lock counter, and invalidates the previous index.
- phase_idx updates only on one-hot samples and otherwise holds. valid follows every sample.
- en=0: no register changes except rearm handling. rev_tick=0. The previous index is retained, so re-enabling continues checking.
- Simultaneous events:
  - rearm in a non-FAULT state is ignored.
  - rearm in FAULT together with a bad sample: rearm wins. The same sample is then treated as the first sample in UNLOCKED.
- rev_count is never cleared by rearm; only clr clears it.

## Timing
- Latency one edge: a sample present at rising edge k is reflected in every output after edge k.
- Reset values (clr=1, asynchronous): phase_idx=0, valid=0, locked=0, rev_tick=0, rev_count=0, err_onehot=0, err_seq=0. State is UNLOCKED, lock counter is 0, previous index is invalid.
- clr asserted mid-revolution or mid-FAULT aborts immediately. The first valid sample after release only establishes the previous index.
- Typical lock after reset with the ring preset to Qa: LOCK_CNT+1 rising edges.

## Structure
- Package ring_pkg holds:
  - NUM_PHASES=6.
  - The state enum (UNLOCKED, LOCKED, FAULT).
  - A next-index helper function (mod-6 increment).
- One sub-module, onehot_enc6: 6-bit one-hot to 3-bit index plus an is_onehot flag. It is purely combinational.
- The top level holds the FSM, lock counter, previous-index register, revolution counter, and flags.

## Test plan
- Reset, then drive 000001,000010,000100,001000 with en=1 and LOCK_CNT=3 → locked=1 after the 4th edge; phase_idx=3.
- Run 3 full revolutions after lock → rev_tick pulses exactly 3 times, each on the 100000→000001 edge; rev_count=3.
- While LOCKED, drive 000011 → err_onehot=1, locked=0, err_seq=0. Pulse rearm → flags clear and lock is reacquired after 3 good advances.
- While LOCKED at idx 2, drive 010000 → err_seq=1. The same pattern in UNLOCKED → no flag; lock counter resets.
- With REV_W=2, run 5 revolutions → rev_count goes 1,2,3,0,1. en=0 for 4 cycles mid-run → all outputs hold and rev_tick stays 0.
- Assert clr between the idx 4 and idx 5 samples → all outputs are 0 immediately. The next samples 100000, 000001 give one advance and no rev_tick.

Source files
------------

// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and helpers for the ring phase monitor: phase count, FSM states
// and the mod-6 successor used by the sequence checker.
package ring_pkg;

  localparam int NUM_PHASES = 6;
  localparam int IDX_W      = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_e;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_PHASES - 1)) ? '0 : idx_t'(i + 1'b1);
  endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Monitor-side bundle: ring inputs and control from the driver, status flags back.
interface ring_phase_monitor_if #(
   parameter int REV_W = 8
);
   import ring_pkg::*;

   logic                  en;
   logic [NUM_PHASES-1:0] phase;
   logic                  rearm;
   idx_t                  phase_idx;
   logic                  valid;
   logic                  locked;
   logic                  rev_tick;
   logic [REV_W-1:0]      rev_count;
   logic                  err_onehot;
   logic                  err_seq;

   modport master (
      output en, phase, rearm,
      input  phase_idx, valid, locked, rev_tick, rev_count, err_onehot, err_seq
   );

   modport slave (
      input  en, phase, rearm,
      output phase_idx, valid, locked, rev_tick, rev_count, err_onehot, err_seq
   );

endinterface

// File: rtl/ring_phase_monitor_onehot_enc6.sv
// Combinational 6-bit one-hot to index encoder with a one-hot validity flag.
module onehot_enc6
   import ring_pkg::*;
(
   input  logic [NUM_PHASES-1:0] phase,
   output idx_t                  idx,
   output logic                  is_onehot
);

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      idx       = '0;
      is_onehot = $onehot(phase);
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (phase[i]) idx = idx_t'(i);
      end
   end

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks the ring counter's one-hot phase for validity and ring order, tracks lock,
// counts revolutions and latches sticky fault flags.
module ring_phase_monitor
   import ring_pkg::*;
#(
   parameter int REV_W    = 8,
   parameter int LOCK_CNT = 3
) (
   input logic                 clk,
   input logic                 clr,
   ring_phase_monitor_if.slave bus
);

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

   idx_t samp_idx;
   logic samp_onehot;

   onehot_enc6 u_enc (
      .phase     (bus.phase),
      .idx       (samp_idx),
      .is_onehot (samp_onehot)
   );

   state_e           state_q,      state_d;
   logic [3:0]       lock_cnt_q,   lock_cnt_d;
   idx_t             prev_idx_q,   prev_idx_d;
   logic             prev_vld_q,   prev_vld_d;
   idx_t             phase_idx_q,  phase_idx_d;
   logic             valid_q,      valid_d;
   logic             rev_tick_q,   rev_tick_d;
   logic [REV_W-1:0] rev_count_q,  rev_count_d;
   logic             err_onehot_q, err_onehot_d;
   logic             err_seq_q,    err_seq_d;

   logic good_adv;

   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      prev_idx_d   = prev_idx_q;
      prev_vld_d   = prev_vld_q;
      phase_idx_d  = phase_idx_q;
      valid_d      = valid_q;
      rev_tick_d   = 1'b0;
      rev_count_d  = rev_count_q;
      err_onehot_d = err_onehot_q;
      err_seq_d    = err_seq_q;

      good_adv = samp_onehot && prev_vld_q && (samp_idx == next_idx(prev_idx_q));

      // Rearm is honoured even while frozen; the current sample then starts afresh.
      if (bus.rearm && state_q == FAULT) begin
         state_d      = UNLOCKED;
         lock_cnt_d   = '0;
         prev_vld_d   = 1'b0;
         err_onehot_d = 1'b0;
         err_seq_d    = 1'b0;
      end

      if (bus.en) begin
         valid_d = samp_onehot;
         if (samp_onehot) begin
            phase_idx_d = samp_idx;
            prev_idx_d  = samp_idx;
            prev_vld_d  = 1'b1;
         end

         unique case (state_q)
            UNLOCKED: begin
               if (!good_adv) begin
                  lock_cnt_d = '0;
               end else if (lock_cnt_q >= LOCK_LAST) begin
                  state_d    = LOCKED;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 4'd1;
               end
            end
            LOCKED: begin
               if (!samp_onehot) begin
                  state_d      = FAULT;
                  err_onehot_d = 1'b1;
               end else if (!good_adv) begin
                  state_d   = FAULT;
                  err_seq_d = 1'b1;
               end else if (samp_idx == '0) begin
                  rev_tick_d  = 1'b1;
                  rev_count_d = rev_count_q + 1'b1;
               end
            end
            FAULT:   ;
            default: state_d = UNLOCKED;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= UNLOCKED;
         lock_cnt_q   <= '0;
         prev_idx_q   <= '0;
         prev_vld_q   <= 1'b0;
         phase_idx_q  <= '0;
         valid_q      <= 1'b0;
         rev_tick_q   <= 1'b0;
         rev_count_q  <= '0;
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         prev_idx_q   <= prev_idx_d;
         prev_vld_q   <= prev_vld_d;
         phase_idx_q  <= phase_idx_d;
         valid_q      <= valid_d;
         rev_tick_q   <= rev_tick_d;
         rev_count_q  <= rev_count_d;
         err_onehot_q <= err_onehot_d;
         err_seq_q    <= err_seq_d;
      end
   end

   assign bus.phase_idx  = phase_idx_q;
   assign bus.valid      = valid_q;
   assign bus.locked     = (state_q == LOCKED);
   assign bus.rev_tick   = rev_tick_q;
   assign bus.rev_count  = rev_count_q;
   assign bus.err_onehot = err_onehot_q;
   assign bus.err_seq    = err_seq_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Drives identical phase streams into an 8-bit and a 2-bit revolution-counter
// instance and compares both against expected records.
module tb_ring_phase_monitor;
   import ring_pkg::*;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   ring_phase_monitor_if #(.REV_W(8)) bus8 ();
   ring_phase_monitor_if #(.REV_W(2)) bus2 ();

   ring_phase_monitor #(.REV_W(8), .LOCK_CNT(3)) dut8 (.clk(clk), .clr(clr), .bus(bus8));
   ring_phase_monitor #(.REV_W(2), .LOCK_CNT(3)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

   typedef struct {
      logic       en;
      logic [5:0] phase;
      logic       rearm;
      logic [2:0] idx;
      logic       valid;
      logic       locked;
      logic       tick;
      int         revs;
      logic       eoh;
      logic       eseq;
   } vec_t;

   vec_t exp_q[$];
   vec_t zero_v;
   int   checks = 0;
   int   errors = 0;
   int   revs   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compare_out(input string tag, input vec_t e);
      logic [7:0] r8;
      logic [1:0] r2;
      r8 = e.revs[7:0];
      r2 = e.revs[1:0];
      check({tag, " idx8"},    32'(bus8.phase_idx),  32'(e.idx));
      check({tag, " valid8"},  32'(bus8.valid),      32'(e.valid));
      check({tag, " locked8"}, 32'(bus8.locked),     32'(e.locked));
      check({tag, " tick8"},   32'(bus8.rev_tick),   32'(e.tick));
      check({tag, " revs8"},   32'(bus8.rev_count),  32'(r8));
      check({tag, " eoh8"},    32'(bus8.err_onehot), 32'(e.eoh));
      check({tag, " eseq8"},   32'(bus8.err_seq),    32'(e.eseq));
      check({tag, " idx2"},    32'(bus2.phase_idx),  32'(e.idx));
      check({tag, " locked2"}, 32'(bus2.locked),     32'(e.locked));
      check({tag, " tick2"},   32'(bus2.rev_tick),   32'(e.tick));
      check({tag, " revs2"},   32'(bus2.rev_count),  32'(r2));
      check({tag, " eoh2"},    32'(bus2.err_onehot), 32'(e.eoh));
      check({tag, " eseq2"},   32'(bus2.err_seq),    32'(e.eseq));
   endtask

   // Drive on the falling edge like the ring counter, compare just after the rising edge.
   task automatic apply_vec(input string tag, input vec_t v);
      vec_t e;
      @(negedge clk);
      bus8.en = v.en;  bus8.phase = v.phase;  bus8.rearm = v.rearm;
      bus2.en = v.en;  bus2.phase = v.phase;  bus2.rearm = v.rearm;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare_out(tag, e);
   endtask

   task automatic apply(input string tag, input logic en, input logic [5:0] ph, input logic rearm,
                        input logic [2:0] idx, input logic valid, input logic locked,
                        input logic tick, input logic eoh, input logic eseq);
      vec_t v;
      v = '{en, ph, rearm, idx, valid, locked, tick, revs, eoh, eseq};
      apply_vec(tag, v);
   endtask

   function automatic logic [5:0] oh(input int i);
      return 6'(1 << i);
   endfunction

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1'b1, 6'b000001, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 6'b000010, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 6'b000100, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 6'b001000, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 6'b010000, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 6'b100000, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 6'b000001, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
      zero_v = '{1'b0, 6'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

      clr = 1'b1;
      bus8.en = 1'b0;  bus8.phase = '0;  bus8.rearm = 1'b0;
      bus2.en = 1'b0;  bus2.phase = '0;  bus2.rearm = 1'b0;
      #12;
      compare_out("reset", zero_v);
      @(negedge clk);
      clr = 1'b0;

      // Acquire lock from Qa, then first wrap
      foreach (tbl[i]) begin
         revs = tbl[i].revs;
         apply_vec($sformatf("lock_tbl%0d", i), tbl[i]);
      end

      // Two more revolutions
      for (int r = 2; r <= 3; r++) begin
         for (int k = 1; k <= 6; k++) begin
            int p;
            p = k % 6;
            if (p == 0) revs++;
            apply("rev", 1'b1, oh(p), 1'b0, 3'(p), 1'b1, 1'b1, (p == 0), 1'b0, 1'b0);
         end
      end

      // Multi-hot while locked, then rearm and relock
      apply("err_oh",        1'b1, 6'b000011, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      apply("fault_enc",     1'b1, oh(1),     1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      apply("rearm",         1'b1, oh(2),     1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("relock1",       1'b1, oh(3),     1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("relock2",       1'b1, oh(4),     1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("relock3",       1'b1, oh(5),     1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      revs++;
      apply("rearm_ignored", 1'b1, oh(0),     1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      apply("adv1",          1'b1, oh(1),     1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply("adv2",          1'b1, oh(2),     1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Out-of-order while locked, rearm together with a bad sample
      apply("err_seq",       1'b1, 6'b010000, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      apply("rearm_bad",     1'b1, 6'b000000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("first",         1'b1, oh(0),     1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("u_adv1",        1'b1, oh(1),     1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("u_adv2",        1'b1, oh(2),     1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("unl_seq",       1'b1, oh(4),     1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("cnt_reset1",    1'b1, oh(5),     1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("cnt_reset2",    1'b1, oh(0),     1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("cnt_reset3",    1'b1, oh(1),     1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Five revolutions (2-bit counter wraps), freeze for 4 cycles after a tick
      for (int r = 0; r < 5; r++) begin
         for (int k = 2; k <= 7; k++) begin
            int p;
            p = k % 6;
            if (p == 0) revs++;
            apply("wrap_rev", 1'b1, oh(p), 1'b0, 3'(p), 1'b1, 1'b1, (p == 0), 1'b0, 1'b0);
            if (r == 1 && p == 0) begin
               for (int f = 0; f < 4; f++)
                  apply("frozen", 1'b0, 6'b110011, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            end
         end
      end

      // Asynchronous clear between idx 4 and idx 5
      apply("pre_clr2", 1'b1, oh(2), 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply("pre_clr3", 1'b1, oh(3), 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply("pre_clr4", 1'b1, oh(4), 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      clr = 1'b1;
      #1;
      revs = 0;
      compare_out("clr_async", zero_v);
      #1;
      clr = 1'b0;
      apply("post_clr5", 1'b1, oh(5), 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("post_clr0", 1'b1, oh(0), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("post_clr1", 1'b1, oh(1), 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply("post_clr2", 1'b1, oh(2), 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
